// File: rtl/denise_clut_pipe_if.sv
// Bus bundle for the colour look-up pipe: register-write port, per-channel
// read requests/indices, per-channel colour results and the clear status.
// master = register host / pixel fetch side, slave = the palette pipe.
interface denise_clut_pipe_if #(
  parameter int ADDR_W = 8,
  parameter int NCH    = 2
);
  // register write side
  logic                    clk7_en;
  logic [8:1]              reg_address_in;
  logic [11:0]             data_in;
  logic [2:0]              bank;
  logic                    loct;
  // read side
  logic                    ehb_en;
  logic [ADDR_W-1:0]       bplxor;
  logic [NCH-1:0]          rd_req;
  logic [NCH*ADDR_W-1:0]   select;
  // results / status
  logic [NCH*24-1:0]       rgb;
  logic [NCH-1:0]          rgb_vld;
  logic                    init_busy;

  modport master (
    output clk7_en, reg_address_in, data_in, bank, loct,
    output ehb_en, bplxor, rd_req, select,
    input  rgb, rgb_vld, init_busy
  );

  modport slave (
    input  clk7_en, reg_address_in, data_in, bank, loct,
    input  ehb_en, bplxor, rd_req, select,
    output rgb, rgb_vld, init_busy
  );
endinterface

// File: rtl/denise_clut_pipe.sv
// Purpose: multi-channel colour look-up table with hi/lo nibble registers,
//          extra-half-brite dimming and a post-reset palette clear.
// Latency: 2 clk from rd_req sample to rgb/rgb_vld; no backpressure, every
//          channel accepts one read per clk and writes never stall reads.
// Ports:   clk, rst_n (async, active low) plus the slave side of
//          denise_clut_pipe_if (write port, read channels, rgb, init_busy).
module denise_clut_pipe #(
  parameter int ADDR_W = 8,
  parameter int NCH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  denise_clut_pipe_if.slave  bus
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
  // in EHB mode only the low five index bits address the palette
  localparam logic [ADDR_W-1:0] EHB_MASK = ADDR_W'(31);

  typedef enum logic {S_INIT, S_RUN} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] idx;
    logic [11:0]       dat;
    logic              lo_only;
  } wr_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
  wr_t               pend, pend_nxt;
  wr_t               req_wr;
  wr_t               mem_wr;
  logic              run;
  logic [7:0]        wr_entry;

  logic [11:0] pal_hi [DEPTH];
  logic [11:0] pal_lo [DEPTH];

  assign run           = (state == S_RUN);
  assign bus.init_busy = (state == S_INIT);

  // --------------------------------------------------------------------
  // Register write decode: colour registers live at 0x180..0x1BE, the
  // bank bits extend the 5-bit register number into the palette index.
  // --------------------------------------------------------------------
  assign wr_entry = {bus.bank, bus.reg_address_in[5:1]};

  always_comb begin
    req_wr         = '0;
    req_wr.vld     = bus.clk7_en && (bus.reg_address_in[8:6] == 3'b110);
    req_wr.idx     = wr_entry[ADDR_W-1:0];
    req_wr.dat     = bus.data_in;
    req_wr.lo_only = bus.loct;
  end

  // --------------------------------------------------------------------
  // Control FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT;
      clr_cnt <= '0;
      pend    <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      pend    <= pend_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Control FSM: next state and the single palette write port.
  // INIT owns the write port for the clear, so host writes are parked in
  // one pending slot (last one wins). In RUN the pending slot drains
  // first unless the incoming write hits the same entry, in which case
  // the newer write supersedes it outright.
  // --------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    pend_nxt    = pend;
    mem_wr      = '0;

    if (state == S_INIT) begin
      mem_wr.vld  = 1'b1;
      mem_wr.idx  = clr_cnt;
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == IDX_LAST) begin
        state_nxt = S_RUN;
      end
      if (req_wr.vld) begin
        pend_nxt = req_wr;
      end
    end else begin
      if (pend.vld) begin
        if (req_wr.vld && (req_wr.idx == pend.idx)) begin
          mem_wr   = req_wr;
          pend_nxt = '0;
        end else begin
          mem_wr   = pend;
          pend_nxt = req_wr.vld ? req_wr : '0;
        end
      end else if (req_wr.vld) begin
        mem_wr = req_wr;
      end
    end
  end

  // --------------------------------------------------------------------
  // Palette storage. Not reset: INIT walks every entry instead.
  // A write committed at edge N is seen by a read sampled at edge N
  // because the array is only read one clk after the request is sampled.
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (mem_wr.vld) begin
      pal_lo[mem_wr.idx] <= mem_wr.dat;
      if (!mem_wr.lo_only) begin
        pal_hi[mem_wr.idx] <= mem_wr.dat;
      end
    end
  end

  // --------------------------------------------------------------------
  // Read channels: sample -> array read -> output register.
  // --------------------------------------------------------------------
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [ADDR_W-1:0] sel;
    logic [ADDR_W-1:0] rd_idx;
    logic              half;
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_idx;
    logic              s1_half;
    logic [11:0]       hi_rd;
    logic [11:0]       lo_rd;
    logic [23:0]       col;
    logic [23:0]       col_dim;
    logic              s2_vld;
    logic [23:0]       s2_dat;
    logic              out_vld;
    logic [23:0]       out_dat;

    assign sel    = bus.select[k*ADDR_W +: ADDR_W];
    assign rd_idx = (bus.ehb_en ? (sel & EHB_MASK) : sel) ^ bus.bplxor;

    // select bit 5 is the half-brite flag; a 5-bit palette has no such bit
    if (ADDR_W > 5) begin : g_ehb
      assign half = bus.ehb_en & sel[5];
    end else begin : g_no_ehb
      assign half = 1'b0;
    end

    assign hi_rd   = pal_hi[s1_idx];
    assign lo_rd   = pal_lo[s1_idx];
    assign col     = {hi_rd[11:8], lo_rd[11:8],
                      hi_rd[7:4],  lo_rd[7:4],
                      hi_rd[3:0],  lo_rd[3:0]};
    // each 8-bit component halved independently
    assign col_dim = {1'b0, col[23:17], 1'b0, col[15:9], 1'b0, col[7:1]};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld  <= 1'b0;
        s1_idx  <= '0;
        s1_half <= 1'b0;
        s2_vld  <= 1'b0;
        s2_dat  <= '0;
        out_vld <= 1'b0;
        out_dat <= '0;
      end else begin
        // requests arriving while the clear runs are dropped
        s1_vld <= bus.rd_req[k] && run;
        if (bus.rd_req[k]) begin
          s1_idx  <= rd_idx;
          s1_half <= half;
        end
        s2_vld <= s1_vld && run;
        if (s1_vld) begin
          s2_dat <= s1_half ? col_dim : col;
        end
        out_vld <= s2_vld && run;
        // rgb holds its last value between valid cycles
        if (s2_vld) begin
          out_dat <= s2_dat;
        end
      end
    end

    assign bus.rgb[k*24 +: 24] = out_dat;
    assign bus.rgb_vld[k]      = out_vld;
  end

endmodule

// File: tb/tb_denise_clut_pipe.sv
module tb_denise_clut_pipe;
  localparam int ADDR_W = 8;
  localparam int NCH    = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  denise_clut_pipe_if #(.ADDR_W(ADDR_W), .NCH(NCH)) bus ();

  denise_clut_pipe #(.ADDR_W(ADDR_W), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference palette, pending-write model and expected-output pipeline
  logic [11:0] m_hi [256];
  logic [11:0] m_lo [256];
  logic [23:0] last_rgb [2];
  bit          pend_vld;
  int          pend_idx;
  logic [11:0] pend_dat;

  typedef struct packed {
    logic [1:0]  vld;
    logic [23:0] rgb1;
    logic [23:0] rgb0;
  } exp_t;
  exp_t exp_q [$];

  typedef struct {
    bit          en;
    logic [7:0]  ra;
    logic [2:0]  bk;
    logic [11:0] d;
    bit          lc;
    logic [7:0]  sel;
    bit          ehb;
    logic [7:0]  bx;
    logic [23:0] exp;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_write(input int idx, input logic [11:0] d, input bit lo_only);
    if (!lo_only) begin
      m_hi[idx] = d;
    end
    m_lo[idx] = d;
  endfunction

  function automatic int model_index(input logic [7:0] sel, input bit ehb, input logic [7:0] bx);
    int s;
    s = int'(sel);
    if (ehb) s = s % 32;
    return (s ^ int'(bx)) % 256;
  endfunction

  function automatic logic [23:0] model_colour(input int idx, input bit half);
    int r, g, b;
    r = int'(m_hi[idx][11:8]) * 16 + int'(m_lo[idx][11:8]);
    g = int'(m_hi[idx][7:4])  * 16 + int'(m_lo[idx][7:4]);
    b = int'(m_hi[idx][3:0])  * 16 + int'(m_lo[idx][3:0]);
    if (half) begin
      r = r / 2;
      g = g / 2;
      b = b / 2;
    end
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  // One clk in RUN: drive, let the model commit the write (write-first),
  // predict the reads, advance, and compare the result due this clk.
  task automatic step(input bit wr, input logic [7:0] ra, input logic [2:0] bk,
                      input logic [11:0] d, input bit lc, input logic [1:0] rq,
                      input logic [7:0] s0, input logic [7:0] s1,
                      input bit ehb, input logic [7:0] bx);
    exp_t e;
    bus.clk7_en        = wr;
    bus.reg_address_in = ra;
    bus.bank           = bk;
    bus.data_in        = d;
    bus.loct           = lc;
    bus.rd_req         = rq;
    bus.select         = {s1, s0};
    bus.ehb_en         = ehb;
    bus.bplxor         = bx;
    if (wr && ra[7:5] == 3'b110) model_write(int'({bk, ra[4:0]}), d, lc);
    e.vld  = rq;
    e.rgb0 = model_colour(model_index(s0, ehb, bx), ehb && s0[5]);
    e.rgb1 = model_colour(model_index(s1, ehb, bx), ehb && s1[5]);
    exp_q.push_back(e);
    @(posedge clk); #1;
    if (exp_q.size() > 2) begin
      e = exp_q.pop_front();
      if (e.vld[0]) last_rgb[0] = e.rgb0;
      if (e.vld[1]) last_rgb[1] = e.rgb1;
      check("model vld", 48'(bus.rgb_vld), 48'(e.vld));
      check("model ch0 rgb", 48'(bus.rgb[23:0]), 48'(last_rgb[0]));
      check("model ch1 rgb", 48'(bus.rgb[47:24]), 48'(last_rgb[1]));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 3'h0, 12'h000, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic read_check(input string name, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [1:0] rq, input bit ehb, input logic [7:0] bx,
                            input logic [23:0] e0, input logic [23:0] e1);
    step(1'b0, 8'h00, 3'h0, 12'h000, 1'b0, rq, s0, s1, ehb, bx);
    idle(2);
    check({name, " vld"}, 48'(bus.rgb_vld), 48'(rq));
    if (rq[0]) check({name, " ch0"}, 48'(bus.rgb[23:0]), 48'(e0));
    if (rq[1]) check({name, " ch1"}, 48'(bus.rgb[47:24]), 48'(e1));
  endtask

  task automatic drive_idle();
    bus.clk7_en        = 1'b0;
    bus.reg_address_in = 8'h00;
    bus.data_in        = 12'h000;
    bus.bank           = 3'h0;
    bus.loct           = 1'b0;
    bus.ehb_en         = 1'b0;
    bus.bplxor         = 8'h00;
    bus.rd_req         = 2'b00;
    bus.select         = 16'h0000;
  endtask

  // Assert reset away from the clock edge, check the asynchronous reset
  // state, release on the next cycle and restart the model.
  task automatic apply_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    check("reset init_busy", 48'(bus.init_busy), 48'h1);
    check("reset rgb_vld", 48'(bus.rgb_vld), 48'h0);
    check("reset rgb", 48'(bus.rgb), 48'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      m_hi[i] = 12'h000;
      m_lo[i] = 12'h000;
    end
    last_rgb[0] = 24'h0;
    last_rgb[1] = 24'h0;
    pend_vld = 1'b0;
    exp_q.delete();
  endtask

  // Wait out the clear with reads hammering, optionally two writes during
  // INIT and one write in the first RUN clk.
  task automatic run_init(input bit iw, input logic [7:0] ra_a, input logic [11:0] d_a,
                          input logic [7:0] ra_b, input logic [11:0] d_b,
                          input bit fw, input logic [7:0] ra_c, input logic [11:0] d_c,
                          input bit lc_c);
    int cyc;
    int vld_seen;
    cyc = 0;
    vld_seen = 0;
    while (bus.init_busy && cyc < 400) begin
      bus.clk7_en = 1'b0;
      bus.rd_req  = 2'b11;
      bus.select  = 16'($urandom);
      if (iw && cyc == 10) begin
        bus.clk7_en = 1'b1; bus.reg_address_in = ra_a; bus.bank = 3'h0;
        bus.data_in = d_a;  bus.loct = 1'b0;
        pend_vld = 1'b1; pend_idx = int'(ra_a[4:0]); pend_dat = d_a;
      end
      if (iw && cyc == 20) begin
        bus.clk7_en = 1'b1; bus.reg_address_in = ra_b; bus.bank = 3'h0;
        bus.data_in = d_b;  bus.loct = 1'b0;
        pend_vld = 1'b1; pend_idx = int'(ra_b[4:0]); pend_dat = d_b;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.rgb_vld != 2'b00) vld_seen++;
    end
    drive_idle();
    if (fw) begin
      bus.clk7_en = 1'b1; bus.reg_address_in = ra_c; bus.bank = 3'h0;
      bus.data_in = d_c;  bus.loct = lc_c;
    end
    check("init_busy cycles", 48'(cyc), 48'd256);
    check("vld during INIT", 48'(vld_seen), 48'd0);
    @(posedge clk); #1;
    bus.clk7_en = 1'b0;
    check("vld after INIT a", 48'(bus.rgb_vld), 48'h0);
    @(posedge clk); #1;
    check("vld after INIT b", 48'(bus.rgb_vld), 48'h0);
    // pending write resolution in the first RUN clk
    if (fw && pend_vld && pend_idx == int'(ra_c[4:0])) begin
      model_write(int'(ra_c[4:0]), d_c, lc_c);
    end else begin
      if (pend_vld) model_write(pend_idx, pend_dat, 1'b0);
      if (fw) model_write(int'(ra_c[4:0]), d_c, lc_c);
    end
    pend_vld = 1'b0;
  endtask

  initial begin
    // {en, reg_address[8:1], bank, data, loct, select, ehb, bplxor, expected rgb}
    tbl[0] = '{1'b1, 8'hC1, 3'd0, 12'hF84, 1'b0, 8'h01, 1'b0, 8'h00, 24'hFF8844};
    tbl[1] = '{1'b1, 8'hC1, 3'd0, 12'h123, 1'b1, 8'h01, 1'b0, 8'h00, 24'hF18243};
    tbl[2] = '{1'b1, 8'hC5, 3'd0, 12'hEEE, 1'b0, 8'h25, 1'b1, 8'h00, 24'h777777};
    tbl[3] = '{1'b1, 8'hC5, 3'd0, 12'hEEE, 1'b0, 8'h05, 1'b1, 8'h00, 24'hEEEEEE};
    tbl[4] = '{1'b1, 8'hDF, 3'd5, 12'h5A3, 1'b0, 8'hBE, 1'b0, 8'h01, 24'h55AA33};
    tbl[5] = '{1'b1, 8'hC5, 3'd4, 12'h888, 1'b0, 8'h25, 1'b1, 8'h80, 24'h444444};
    tbl[6] = '{1'b1, 8'hA5, 3'd0, 12'hFFF, 1'b0, 8'h05, 1'b0, 8'h00, 24'hEEEEEE};
    tbl[7] = '{1'b0, 8'hC5, 3'd0, 12'h000, 1'b0, 8'h05, 1'b0, 8'h00, 24'hEEEEEE};
    tbl[8] = '{1'b1, 8'hC1, 3'd7, 12'h369, 1'b0, 8'h1E, 1'b0, 8'hFF, 24'h336699};
    tbl[9] = '{1'b1, 8'hC0, 3'd3, 12'hBBB, 1'b0, 8'hE1, 1'b1, 8'hE0, 24'h19334C};

    rst_n = 1'b0;
    drive_idle();
    #12;

    // clear after reset, then every entry reads black
    apply_reset();
    run_init(1'b0, 8'h00, 12'h000, 8'h00, 12'h000, 1'b0, 8'h00, 12'h000, 1'b0);
    read_check("post-init", 8'h7F, 8'hFF, 2'b11, 1'b0, 8'h00, 24'h000000, 24'h000000);

    // directed write/read table
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].ra, tbl[i].bk, tbl[i].d, tbl[i].lc,
           2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
      read_check($sformatf("table[%0d]", i), tbl[i].sel, 8'h00, 2'b01,
                 tbl[i].ehb, tbl[i].bx, tbl[i].exp, 24'h0);
    end

    // write and read of the same entry at the same edge: new data
    step(1'b1, 8'hC3, 3'd0, 12'h3C3, 1'b0, 2'b01, 8'h03, 8'h00, 1'b0, 8'h00);
    idle(2);
    check("collision same-edge", 48'(bus.rgb[23:0]), 48'h33CC33);
    // read one clk ahead of the write: old data
    step(1'b0, 8'h00, 3'd0, 12'h000, 1'b0, 2'b01, 8'h03, 8'h00, 1'b0, 8'h00);
    step(1'b1, 8'hC3, 3'd0, 12'h7A1, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
    idle(1);
    check("collision early vld", 48'(bus.rgb_vld[0]), 48'h1);
    check("collision early rgb", 48'(bus.rgb[23:0]), 48'h33CC33);
    idle(1);
    read_check("collision after", 8'h03, 8'h00, 2'b01, 1'b0, 8'h00, 24'h77AA11, 24'h0);

    // both channels in the same clk with a shared bplxor
    step(1'b1, 8'hC0, 3'd0, 12'h0F0, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
    step(1'b1, 8'hC1, 3'd0, 12'hA5A, 1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 8'h00);
    read_check("dual", 8'h00, 8'h01, 2'b11, 1'b0, 8'h01, 24'hAA55AA, 24'h00FF00);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 2) == 0),
           {(($urandom_range(0, 3) != 0) ? 3'b110 : 3'($urandom)), 5'($urandom)},
           3'($urandom), 12'($urandom), 1'($urandom),
           2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
           (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom)));
    end
    idle(3);

    // reset mid-RUN, then again mid-INIT; the clear restarts from entry 0
    apply_reset();
    repeat (100) begin
      @(posedge clk); #1;
    end
    check("mid-INIT busy", 48'(bus.init_busy), 48'h1);
    apply_reset();
    run_init(1'b1, 8'hC2, 12'hABC, 8'hC4, 12'h555, 1'b0, 8'h00, 12'h000, 1'b0);
    read_check("init pend", 8'h04, 8'h02, 2'b11, 1'b0, 8'h00, 24'h555555, 24'h000000);
    read_check("re-cleared", 8'h85, 8'h03, 2'b11, 1'b0, 8'h00, 24'h000000, 24'h000000);

    // pending write plus a different-entry write in the first RUN clk
    apply_reset();
    run_init(1'b1, 8'hC6, 12'h111, 8'hC6, 12'h111, 1'b1, 8'hC7, 12'h222, 1'b0);
    read_check("first-run other", 8'h06, 8'h07, 2'b11, 1'b0, 8'h00, 24'h111111, 24'h222222);

    // same-entry write in the first RUN clk supersedes the pending one
    apply_reset();
    run_init(1'b1, 8'hC6, 12'h111, 8'hC6, 12'h111, 1'b1, 8'hC6, 12'h999, 1'b1);
    read_check("first-run same", 8'h06, 8'h07, 2'b11, 1'b0, 8'h00, 24'h090909, 24'h000000);

    for (int i = 0; i < 150; i++) begin
      step(($urandom_range(0, 2) == 0), {3'b110, 5'($urandom)},
           3'($urandom), 12'($urandom), 1'($urandom),
           2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom));
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/denise_clut_pipe.md
DENISE_CLUT_PIPE -- requirements
Module: denise_clut_pipe

Interface
REQ-001 Parameter ADDR_W, default 8, meaning palette index width; depth = 2^ADDR_W entries, ADDR_W in 5..8.
REQ-002 Parameter NCH, default 2, meaning number of independent read channels, 1..4.
REQ-003 Port clk  input  1  28MHz clock; one clock domain only.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port clk7_en  input  1  7MHz enable qualifying register writes.
REQ-006 Port reg_address_in  input  8 ([8:1])  custom register address.
REQ-007 Port data_in  input  12  colour register data, 4 bits each of R, G, B.
REQ-008 Port bank  input  3  colour bank select.
REQ-009 Port loct  input  1  1 = low-nibble write.
REQ-010 Port ehb_en  input  1  extra-half-brite enable.
REQ-011 Port bplxor  input  ADDR_W  read index XOR value.
REQ-012 Port rd_req  input  NCH  per-channel read request.
REQ-013 Port select  input  NCH*ADDR_W  per-channel colour index; channel k uses bits [k*ADDR_W +: ADDR_W].
REQ-014 Port rgb  output  NCH*24  per-channel colour {R8,G8,B8}.
REQ-015 Port rgb_vld  output  NCH  per-channel output valid.
REQ-016 Port init_busy  output  1  palette clear in progress.

Function
REQ-017 Write hit: reg_address_in[8:6]==3'b110 and clk7_en==1; entry = {bank, reg_address_in[5:1]} truncated to its low ADDR_W bits.
REQ-018 Each entry stores hi[11:0] and lo[11:0]; loct=0 writes data_in to both hi and lo; loct=1 writes lo only, hi unchanged.
REQ-019 Colour packing: rgb = {hiR, loR, hiG, loG, hiB, loB}, 4 bits each.
REQ-020 Read index per channel: ehb_en=1 -> {zeros, select[4:0]} ^ bplxor; ehb_en=0 -> select ^ bplxor (full ADDR_W).
REQ-021 EHB: ehb_en=1 and select bit 5 = 1 -> each 8-bit component shifted right by 1, MSB 0; ehb_en and select are sampled together with rd_req.
REQ-022 Read latency 2 clk: rd_req sampled at edge N -> rgb and rgb_vld valid after edge N+2; fully pipelined, one read per channel per clk.
REQ-023 rgb_vld[k] = rd_req[k] delayed 2 clk; while rgb_vld[k]=0, rgb[k] holds its last value.
REQ-024 Write/read collision: a write committed at edge N is visible to any read sampled at edge N or later (write-first bypass); reads sampled before N return old data.
REQ-025 All channels read concurrently without stall; reads never block writes.
REQ-026 FSM states INIT, RUN; rst_n deassert -> INIT.
REQ-027 INIT: counter 0..2^ADDR_W-1 clears one entry per clk (hi=lo=0); after the last entry -> RUN on next edge; init_busy=1 throughout INIT, 0 in RUN.
REQ-028 During INIT: rgb_vld forced 0; rd_req ignored.
REQ-029 Writes during INIT go to a single pending register, last write wins (loct captured); applied on the first RUN clk.
REQ-030 A new write in the first RUN clk takes priority over the pending write only if it targets the same entry; otherwise the pending write is applied and the new write is applied the next clk.

Reset
REQ-031 rst_n=0 asynchronously sets: rgb=0, rgb_vld=0, init_busy=1, FSM=INIT, counter=0, pending cleared, read pipeline cleared.
REQ-032 Reset asserted mid-INIT or mid-RUN restarts the clear from entry 0; palette contents are not guaranteed until INIT completes.

Verification
REQ-033 Release reset, ADDR_W=8 -> init_busy=1 for exactly 256 clk then 0; read any index -> rgb=24'h000000.
REQ-034 Write addr 0x182, bank=0, data=12'hF84, loct=0, then loct=1 data=12'h123; read select=1, bplxor=0 -> rgb=24'hF18243 two clk later.
REQ-035 Entry 5 = 12'hEEE (loct=0), ehb_en=1, select=6'h25 -> rgb=24'h777777; select=6'h05 -> 24'hEEEEEE.
REQ-036 Write entry 3 and rd_req with index 3 at the same edge -> new data on rgb after 2 clk; read one clk earlier -> old data.
REQ-037 Two writes during INIT (entry 2=12'hABC, then entry 4=12'h555) -> after INIT entry 4=24'h555555, entry 2=0.
REQ-038 NCH=2, channel 0 index 1, channel 1 index 1^bplxor=8'h01 (index 0) on the same clk -> both rgb_vld=1 two clk later with the matching colours.
